// File: rtl/ws2812_line_decoder.sv
// ws2812_line_decoder: WS2812 single-wire receiver producing indexed GRB pixels and frame status.
// Optional macro WS2812_DECODER_GLITCH_FILTER_EN drops high pulses shorter than GLITCH_CLK.
`timescale 1ns/1ps
`default_nettype none

module ws2812_line_decoder #(
    parameter int MAX_POS           = 109,
    parameter int BIT_THRESHOLD_CLK = 30,
    parameter int HIGH_TIMEOUT_CLK  = 100,
    parameter int RESET_CLK_CNT     = 2500,
    parameter int GLITCH_CLK        = 4,
    localparam int IDX_W            = $clog2(MAX_POS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_in,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic [7:0]       pixel_green,
    output logic [7:0]       pixel_red,
    output logic [7:0]       pixel_blue,
    output logic             frame_done,
    output logic [IDX_W:0]   frame_pixel_count,
    output logic             err_partial,
    output logic             err_overflow,
    output logic             err_timeout
);

    localparam int HW = $clog2(HIGH_TIMEOUT_CLK + 1);
    localparam int LW = $clog2(RESET_CLK_CNT + 1);
    localparam int PW = IDX_W + 1;

    localparam logic [HW-1:0] HIGH_MAX   = HW'(HIGH_TIMEOUT_CLK);
    localparam logic [HW-1:0] BIT_TH     = HW'(BIT_THRESHOLD_CLK);
    localparam logic [HW-1:0] GLITCH_MIN = HW'(GLITCH_CLK);
    localparam logic [LW-1:0] LOW_END    = LW'(RESET_CLK_CNT);
    localparam logic [PW-1:0] PIX_LAST   = PW'(MAX_POS);
    localparam logic [PW-1:0] PIX_SAT    = PW'(MAX_POS + 2);

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    state_t         state, state_next;
    logic           line_meta, line_s, line_prev;
    logic [HW-1:0]  hcnt;
    logic [LW-1:0]  lcnt;
    logic [4:0]     bitcnt;
    logic [PW-1:0]  pixcnt;
    logic [22:0]    shreg;

    logic           rise, fall;
    logic [HW-1:0]  hcnt_plus;
    logic [LW-1:0]  lcnt_plus;
    logic           bit_val, glitch_pulse;
    logic [23:0]    word_next;
    logic           start_frame, high_again, bit_accept, frame_end, timeout_hit;
    logic           last_bit, overflow_hit;

    assign rise      = line_s & ~line_prev;
    assign fall      = ~line_s & line_prev;
    assign hcnt_plus = (hcnt == HIGH_MAX) ? hcnt : hcnt + 1'b1;
    assign lcnt_plus = (lcnt == LOW_END) ? lcnt : lcnt + 1'b1;
    assign bit_val   = (hcnt >= BIT_TH);
    assign word_next = {shreg, bit_val};

`ifdef WS2812_DECODER_GLITCH_FILTER_EN
    assign glitch_pulse = (hcnt < GLITCH_MIN);
`else
    // Filter disabled: every high pulse counts as a bit.
    assign glitch_pulse = (hcnt < GLITCH_MIN) & 1'b0;
`endif

    assign last_bit     = bit_accept && (bitcnt == 5'd23);
    assign overflow_hit = last_bit && (pixcnt > PIX_LAST);

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        high_again  = 1'b0;
        bit_accept  = 1'b0;
        frame_end   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_RESYNC: begin
                if (!line_s && lcnt_plus == LOW_END) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    state_next  = ST_HIGH;
                    start_frame = 1'b1;
                end
            end
            ST_HIGH: begin
                if (hcnt >= HIGH_MAX) begin
                    state_next  = ST_RESYNC;
                    timeout_hit = 1'b1;
                end else if (fall) begin
                    state_next = ST_LOW;
                    bit_accept = ~glitch_pulse;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_next = ST_HIGH;
                    high_again = 1'b1;
                end else if (lcnt_plus == LOW_END) begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= ST_RESYNC;
            line_meta         <= 1'b0;
            line_s            <= 1'b0;
            line_prev         <= 1'b0;
            hcnt              <= '0;
            lcnt              <= '0;
            bitcnt            <= '0;
            pixcnt            <= '0;
            shreg             <= '0;
            pixel_valid       <= 1'b0;
            pixel_index       <= '0;
            pixel_green       <= '0;
            pixel_red         <= '0;
            pixel_blue        <= '0;
            frame_done        <= 1'b0;
            frame_pixel_count <= '0;
            err_partial       <= 1'b0;
            err_overflow      <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            line_meta   <= line_in;
            line_s      <= line_meta;
            line_prev   <= line_s;
            state       <= state_next;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;

            if (start_frame || high_again) hcnt <= HW'(1);
            else if (state == ST_HIGH)     hcnt <= hcnt_plus;

            // A discarded glitch leaves the low count untouched so the gap keeps accumulating.
            if (start_frame || timeout_hit)        lcnt <= '0;
            else if (bit_accept)                   lcnt <= LW'(1);
            else if (state == ST_RESYNC)           lcnt <= line_s ? '0 : lcnt_plus;
            else if (state == ST_LOW && !rise)     lcnt <= lcnt_plus;

            if (start_frame || timeout_hit) begin
                bitcnt <= '0;
                pixcnt <= start_frame ? '0 : pixcnt;
            end

            if (bit_accept) begin
                shreg <= word_next[22:0];
                if (last_bit) begin
                    bitcnt <= '0;
                    if (pixcnt <= PIX_LAST) begin
                        pixel_valid <= 1'b1;
                        pixel_index <= pixcnt[IDX_W-1:0];
                        pixel_green <= word_next[23:16];
                        pixel_red   <= word_next[15:8];
                        pixel_blue  <= word_next[7:0];
                    end
                    if (pixcnt != PIX_SAT) pixcnt <= pixcnt + 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end

            if (frame_end) begin
                frame_done        <= 1'b1;
                frame_pixel_count <= pixcnt;
            end

            // Sticky flags clear the cycle after frame_done; a new error in that cycle wins.
            err_partial  <= (frame_end && bitcnt != 5'd0) | (err_partial & ~frame_done);
            err_overflow <= overflow_hit | (err_overflow & ~frame_done);
            err_timeout  <= timeout_hit | (err_timeout & ~frame_done);
        end
    end

endmodule

`default_nettype wire

// File: doc/ws2812_line_decoder.md
# ws2812_line_decoder

Receiver for the single-wire WS2812 LED stream that the racer top level drives on `leds_line`. It samples the serial line, classifies each high pulse as a 0 or 1 bit by its width, and assembles 24-bit GRB pixels tagged with their position on the strip. It detects the inter-frame reset gap and reports frame completion, partial pixels, over-length frames and stuck-high lines. It sits on a loopback test point or a daisy-chained display board and lets the bench or on-board logic check frames without a physical strip.

## Interface
Parameters:
- `MAX_POS`, 109, highest valid pixel index; the index width is `IDX_W = $clog2(MAX_POS+1)`.
- `BIT_THRESHOLD_CLK`, 30, high-pulse width (clk cycles) at or above which the bit is 1.
- `HIGH_TIMEOUT_CLK`, 100, high-pulse width that flags the line as stuck high.
- `RESET_CLK_CNT`, 2500, low-run length that ends a frame (50 µs at 50 MHz).
- `GLITCH_CLK`, 4, minimum accepted high-pulse width; used only with the macro.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `line_in`  in  1  asynchronous WS2812 data line.
- `pixel_valid`  out  1  one-cycle strobe; the pixel fields below are valid.
- `pixel_index`  out  IDX_W  position of the pixel within the frame, starting at 0.
- `pixel_green`, `pixel_red`, `pixel_blue`  out  8 each  colour bytes, MSB first on the wire, in GRB order.
- `frame_done`  out  1  one-cycle strobe at the end of a frame.
- `frame_pixel_count`  out  IDX_W+1  number of complete pixels received; updated with `frame_done`.
- `err_partial`  out  1  frame ended with 1–23 leftover bits.
- `err_overflow`  out  1  more than MAX_POS+1 pixels were received.
- `err_timeout`  out  1  the line stayed high for HIGH_TIMEOUT_CLK cycles.

## Operation
- `line_in` passes through a 2-FF synchronizer. Edge detection works on the synchronized sample.
- States:
  - RESYNC (the reset state): counts consecutive low cycles. After RESET_CLK_CNT of them it moves to IDLE with no `frame_done`. Any high sample restarts the count.
  - IDLE: a rising edge moves to HIGH. The high counter starts at 1 and the bit and pixel counters are cleared.
  - HIGH: the high counter increments. On a falling edge the bit is `hcnt >= BIT_THRESHOLD_CLK`; it shifts into the 24-bit register MSB-first and the state moves to LOW with the low counter at 1. If `hcnt` reaches HIGH_TIMEOUT_CLK, `err_timeout` is set and the state moves to RESYNC. The partial pixel is discarded.
  - LOW: a rising edge moves to HIGH. If the low counter reaches RESET_CLK_CNT, `frame_done` pulses and the state moves to IDLE. At that point `err_partial` is set if the bit count is not 0, and `frame_pixel_count` takes the pixel count saturated at MAX_POS+2.
- On the 24th bit:
  - If the pixel count is at most MAX_POS, `pixel_valid` pulses with index = pixel count, and the pixel count increments.
  - Otherwise `err_overflow` is set and no strobe is issued.
- Error flags are sticky and clear on reset or on the cycle after the next `frame_done`. An error raised in the same cycle as the clear wins.
- Counters saturate and never wrap.
- Reset mid-frame discards all state and returns to RESYNC.

## Timing
- Reset values: all outputs 0; `pixel_*` fields 0; state RESYNC.
- Synchronizer latency: 2 cycles; the falling edge is recognised on the 3rd cycle after the line falls.
- `pixel_valid` is registered. It asserts one cycle after the falling edge of the 24th bit is recognised, and the fields hold until the next strobe.
- `frame_done` asserts on the cycle the low counter reaches RESET_CLK_CNT. The count fields and error flags are stable from that cycle.
- Boundary widths:
  - `hcnt == BIT_THRESHOLD_CLK-1` gives bit 0; `== BIT_THRESHOLD_CLK` gives bit 1.
  - A low run of RESET_CLK_CNT-1 followed by high continues the frame.
- Minimum supported bit period: 4 cycles.

## Configuration
- `WS2812_DECODER_GLITCH_FILTER_EN` defined:
  - High pulses shorter than GLITCH_CLK cycles are discarded: no bit is shifted, and the state returns to LOW keeping its current low count.
- Not defined:
  - Every high pulse of at least 1 cycle is a bit.
  - GLITCH_CLK is ignored.

## Test plan
- After a 2500-cycle low run, send one pixel G=0xA5 R=0x3C B=0xFF using 20-cycle highs for 0 and 40-cycle highs for 1, then a 2600-cycle low -> one `pixel_valid` with index 0, G=A5 R=3C B=FF; then `frame_done`, count 1, no errors.
- Send 110 pixels, then 111 pixels -> indices 0..109 strobe in both frames. The second frame sets `err_overflow` and reports count 111.
- Send 30 bits and end the frame -> one pixel strobe; `err_partial`=1 with `frame_done`.
- Hold the line high 100 cycles -> `err_timeout`=1 and state RESYNC; no `frame_done` until a full 2500-cycle low is followed by a valid frame.
- Send 29- and 30-cycle highs, and a 2499-cycle low inside a frame -> bits 0 and 1 respectively; the frame continues without `frame_done`.
- With the macro, insert 2-cycle spikes between bits -> pixel values unchanged. Without the macro -> extra 0 bits are shifted in.
